// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the iterative RV32M divider.
package div_unit_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT  = '1;
  localparam logic [XLEN_DEF-1:0] SIGNED_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};

  // Bit 0 of the op code selects unsigned operation; bit 1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the register file, control and the divider.
interface div_unit_if #(
  parameter int unsigned XLEN = div_unit_pkg::XLEN_DEF
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract when it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] sh;
  logic          ge;

  always_comb begin
    sh    = {rem_i, quo_i[XLEN-1]};
    ge    = (sh >= {1'b0, dvs_i});
    rem_o = ge ? (sh[XLEN-1:0] - dvs_i) : sh[XLEN-1:0];
    quo_o = {quo_i[XLEN-2:0], ge};
  end
endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit: FSM, counter, sign handling and output registers.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int unsigned     CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [4:0]      rd_q, rd_out_q;
  logic            neg_q_q, neg_r_q, sel_rem_q;

  logic [XLEN-1:0] rem_d, quo_d, fix_q_d, fix_r_d;
  logic [XLEN-1:0] abs1, abs2;
  logic            sgn1, sgn2, div0, ovf;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_comb begin
    sgn1    = op_is_signed(bus.op) & bus.rs1_data[XLEN-1];
    sgn2    = op_is_signed(bus.op) & bus.rs2_data[XLEN-1];
    abs1    = sgn1 ? -bus.rs1_data : bus.rs1_data;
    abs2    = sgn2 ? -bus.rs2_data : bus.rs2_data;
    div0    = (bus.rs2_data == '0);
    ovf     = op_is_signed(bus.op) && (bus.rs1_data == SMIN) && (bus.rs2_data == '1);
    fix_q_d = neg_q_q ? -quo_d : quo_d;
    fix_r_d = neg_r_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_q <= sel_rem_q ? fix_r_d : fix_q_d;
            rd_out_q <= rd_q;
            state_q  <= DONE;
          end
        end
        default: begin
          if (bus.start) begin
            sel_rem_q <= bus.op[1];
            rd_q      <= bus.rd_in;
            quo_q     <= abs1;
            dvs_q     <= abs2;
            rem_q     <= '0;
            cnt_q     <= '0;
            // Divide-by-zero quotient is all ones regardless of signs, so never negate it.
            neg_q_q   <= (sgn1 ^ sgn2) && !div0;
            neg_r_q   <= sgn1;
            if (FAST_SPECIAL && (div0 || ovf)) begin
              result_q <= bus.op[1] ? (div0 ? bus.rs1_data : '0)
                                    : (div0 ? '1 : SMIN);
              rd_out_q <= bus.rd_in;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench: two dividers (fast special cases on/off) driven with identical directed vectors.
module tb_div_unit;
  import div_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned lat;
    int unsigned bsy;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned bc0 = 0;
  int unsigned bc1 = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  div_unit_if #(.XLEN(32)) b0 ();
  div_unit_if #(.XLEN(32)) b1 ();

  div_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) u_fast (.clk(clk), .rst(rst), .bus(b0));
  div_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) u_slow (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_in(input logic s, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    b0.start = s; b0.op = op; b0.rs1_data = a; b0.rs2_data = b; b0.rd_in = rd;
    b1.start = s; b1.op = op; b1.rs1_data = a; b1.rs2_data = b; b1.rd_in = rd;
  endtask

  // Accept happens on the posedge following the drive; 'special' selects zero latency on the fast unit.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input bit special,
                       input bit hold);
    exp_t e;
    @(negedge clk);
    set_in(1'b1, op, a, b, rd);
    @(posedge clk);
    #1;
    e = '{res: res, rd: rd, lat: special ? 0 : 32, bsy: special ? 0 : 32, acc: cyc};
    q0.push_back(e);
    e.lat = 32; e.bsy = 32;
    q1.push_back(e);
    if (!hold) begin
      b0.start = 1'b0; b1.start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: %0d/%0d results never arrived", q0.size(), q1.size());
      q0.delete(); q1.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) bc0 = 0;
    else begin
      if (b0.busy) bc0++;
      if (b0.done) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fast_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("fast_result", b0.result, e.res);
          chk("fast_rd_out", 32'(b0.rd_out), 32'(e.rd));
          chk("fast_latency", cyc - e.acc, e.lat);
          chk("fast_busy_cycles", bc0, e.bsy);
        end
        bc0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) bc1 = 0;
    else begin
      if (b1.busy) bc1++;
      if (b1.done) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL slow_unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("slow_result", b1.result, e.res);
          chk("slow_rd_out", 32'(b1.rd_out), 32'(e.rd));
          chk("slow_latency", cyc - e.acc, e.lat);
          chk("slow_busy_cycles", bc1, e.bsy);
        end
        bc1 = 0;
      end
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_fast_busy"},   32'(b0.busy), 32'd0);
    chk({tag, "_fast_done"},   32'(b0.done), 32'd0);
    chk({tag, "_fast_result"}, b0.result, 32'd0);
    chk({tag, "_fast_rd_out"}, 32'(b0.rd_out), 32'd0);
    chk({tag, "_slow_busy"},   32'(b1.busy), 32'd0);
    chk({tag, "_slow_done"},   32'(b1.done), 32'd0);
    chk({tag, "_slow_result"}, b1.result, 32'd0);
    chk({tag, "_slow_rd_out"}, 32'(b1.rd_out), 32'd0);
  endtask

  initial begin
    set_in(1'b0, OP_DIV, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b1;

    // Normal divisions
    issue(OP_DIVU, 32'd20,         32'd3,          5'd5,  32'd6,          1'b0, 1'b0); wait_idle();
    issue(OP_DIV,  32'hFFFF_FFEC,  32'd3,          5'd6,  32'hFFFF_FFFA,  1'b0, 1'b0); wait_idle();
    issue(OP_REM,  32'hFFFF_FFEC,  32'd3,          5'd7,  32'hFFFF_FFFE,  1'b0, 1'b0); wait_idle();
    issue(OP_DIV,  32'd20,         32'hFFFF_FFFD,  5'd8,  32'hFFFF_FFFA,  1'b0, 1'b0); wait_idle();
    issue(OP_REM,  32'd20,         32'hFFFF_FFFD,  5'd9,  32'd2,          1'b0, 1'b0); wait_idle();
    issue(OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd10, 32'hFFFF_FFFF,  1'b0, 1'b0); wait_idle();
    issue(OP_REMU, 32'd100,        32'd7,          5'd11, 32'd2,          1'b0, 1'b0); wait_idle();

    // Divide by zero and signed overflow
    issue(OP_DIVU, 32'd7,          32'd0,          5'd12, 32'hFFFF_FFFF,  1'b1, 1'b0); wait_idle();
    issue(OP_REMU, 32'd7,          32'd0,          5'd13, 32'd7,          1'b1, 1'b0); wait_idle();
    issue(OP_DIV,  32'hFFFF_FFF9,  32'd0,          5'd14, 32'hFFFF_FFFF,  1'b1, 1'b0); wait_idle();
    issue(OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd15, 32'hFFFF_FFF9,  1'b1, 1'b0); wait_idle();
    issue(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1'b1, 1'b0); wait_idle();
    issue(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          1'b1, 1'b0); wait_idle();

    // start during CALC is ignored
    issue(OP_DIVU, 32'd100,        32'd7,          5'd18, 32'd14,         1'b0, 1'b0);
    repeat (9) @(negedge clk);
    set_in(1'b1, OP_REM, 32'd5, 32'd2, 5'd30);
    @(negedge clk);
    set_in(1'b0, OP_REM, 32'd5, 32'd2, 5'd30);
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    set_in(1'b1, OP_DIVU, 32'd100, 32'd7, 5'd19);
    @(posedge clk);
    #1;
    set_in(1'b0, OP_DIVU, 32'd100, 32'd7, 5'd19);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("midrst");
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Back-to-back: start held high so the second op is accepted on the DONE edge
    issue(OP_DIVU, 32'd100,        32'd7,          5'd20, 32'd14,         1'b0, 1'b1);
    @(negedge clk);
    set_in(1'b1, OP_REMU, 32'd100, 32'd7, 5'd21);
    for (int i = 0; i < 100; i++) begin
      if (b0.done) break;
      @(negedge clk);
    end
    if (!b0.done) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_wait_done: got done=0 expected done=1");
    end
    issue_second();
    wait_idle();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Second half of the back-to-back case: inputs already driven, accept on the next edge.
  task automatic issue_second();
    exp_t e;
    @(posedge clk);
    #1;
    e = '{res: 32'd2, rd: 5'd21, lat: 32, bsy: 32, acc: cyc};
    q0.push_back(e);
    q1.push_back(e);
    b0.start = 1'b0; b1.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
